// File: rtl/screen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : screen (package)
// Description : Shared screen-side types: the top-level system state, the
//               board geometry constants, pixel colour codes and the local
//               state encoding of the cell renderer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package screen;

  // Top-level sequencing state; cell_done moves SYS_CELL_DRAW back to idle.
  typedef enum logic [1:0] {
    SYS_IDLE      = 2'd0,
    SYS_SCAN      = 2'd1,
    SYS_CELL_DRAW = 2'd2
  } sys_state_t;

  localparam int CELL_PX     = 16;
  localparam int BOARD_CELLS = 9;

  typedef enum logic [1:0] {
    PIX_BG    = 2'd0,
    PIX_THIN  = 2'd1,
    PIX_THICK = 2'd2,
    PIX_INK   = 2'd3
  } pix_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } rend_state_t;

endpackage
`default_nettype wire

// File: rtl/cell_renderer_glyph.sv
`default_nettype none
// ============================================================================
// Module      : digit_glyph_rom
// Description : Combinational 8x8 digit font for the values 1..9. Every other
//               digit code reads back as an empty row.
// Ports       : digit     in  [3:0]  cell value
//               glyph_row in  [2:0]  row inside the glyph, 0 = top
//               row_bits  out [7:0]  pixels of that row, bit 7 = leftmost
// Revision    : 1.0 - initial release
// ============================================================================
module digit_glyph_rom (
  input  logic [3:0] digit,
  input  logic [2:0] glyph_row,
  output logic [7:0] row_bits
);

  // Whole glyph packed with the top row in the most significant byte.
  logic [63:0] glyph;

  always_comb begin
    glyph = 64'h0;
    case (digit)
      4'd1:    glyph = 64'h1838_1818_1818_7E00;
      4'd2:    glyph = 64'h3C66_060C_3060_7E00;
      4'd3:    glyph = 64'h3C66_061C_0666_3C00;
      4'd4:    glyph = 64'h0C1C_3C6C_7E0C_0C00;
      4'd5:    glyph = 64'h7E60_7C06_0666_3C00;
      4'd6:    glyph = 64'h3C60_7C66_6666_3C00;
      4'd7:    glyph = 64'h7E06_0C18_3030_3000;
      4'd8:    glyph = 64'h3C66_663C_6666_3C00;
      4'd9:    glyph = 64'h3C66_663E_060C_3800;
      default: glyph = 64'h0;
    endcase
  end

  always_comb begin
    row_bits = 8'h00;
    case (glyph_row)
      3'd0:    row_bits = glyph[63:56];
      3'd1:    row_bits = glyph[55:48];
      3'd2:    row_bits = glyph[47:40];
      3'd3:    row_bits = glyph[39:32];
      3'd4:    row_bits = glyph[31:24];
      3'd5:    row_bits = glyph[23:16];
      3'd6:    row_bits = glyph[15:8];
      default: row_bits = glyph[7:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cell_renderer.sv
`default_nettype none
// ============================================================================
// Module      : cell_renderer
// Description : Rasterises one 16x16 board cell (grid lines plus a digit
//               glyph) into the framebuffer write port, one pixel per
//               accepted write, in raster order.
// Ports       : clk, rst            clock, synchronous active-high reset
//               start_cell          request level, rising edge starts a cell
//               cell_row/col/data   cell coordinates and value
//               fb_ready            framebuffer accepts a write this cycle
//               fb_we/x/y/pixel     framebuffer write port
//               busy                cell in progress
//               cell_done/cell_err  completion pulse, error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cell_renderer #(
  parameter int CELL_PX = 16,
  parameter int GRID_X0 = 8,
  parameter int GRID_Y0 = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_cell,
  input  logic [3:0] cell_row,
  input  logic [3:0] cell_col,
  input  logic [3:0] cell_data,
  input  logic       fb_ready,
  output logic       fb_we,
  output logic [7:0] fb_x,
  output logic [7:0] fb_y,
  output logic [1:0] fb_pixel,
  output logic       busy,
  output logic       cell_done,
  output logic       cell_err
);

  import screen::*;

  rend_state_t state, state_nx;

  logic       start_q;
  logic [3:0] row_r, col_r, dat_r;
  logic [3:0] px, py;
  logic       err_r;

  logic       start;
  logic       in_range;
  logic       accept;
  logic       last_px;

  // Edge detect only counts while idle, so edges during a draw are dropped.
  assign start    = start_cell & ~start_q & (state == S_IDLE);
  assign in_range = (cell_row <= 4'd8) && (cell_col <= 4'd8);
  assign accept   = (state == S_DRAW) & fb_ready;
  assign last_px  = accept && (px == 4'd15) && (py == 4'd15);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = in_range ? S_DRAW : S_DONE;
      S_DRAW: if (last_px) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      row_r   <= 4'd0;
      col_r   <= 4'd0;
      dat_r   <= 4'd0;
      px      <= 4'd0;
      py      <= 4'd0;
      err_r   <= 1'b0;
    end else begin
      start_q <= start_cell;
      if (start && in_range) begin
        row_r <= cell_row;
        col_r <= cell_col;
        dat_r <= cell_data;
        px    <= 4'd0;
        py    <= 4'd0;
      end
      if (start && !in_range) begin
        err_r <= 1'b1;
      end
      if (accept) begin
        px <= px + 4'd1;
        if (px == 4'd15) begin
          py <= py + 4'd1;
        end
      end
      if (state == S_DONE) begin
        err_r <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------- pixel colour
  logic [2:0] glyph_row;
  logic [2:0] glyph_col;
  logic [7:0] glyph_bits;
  logic       thick, thin, ink_area, ink;
  pix_t       colour;

  assign glyph_row = 3'(py - 4'd4);
  assign glyph_col = 3'(px - 4'd4);

  digit_glyph_rom u_glyph (
    .digit     (dat_r),
    .glyph_row (glyph_row),
    .row_bits  (glyph_bits)
  );

  always_comb begin
    // Box boundaries sit on the left/top edge of columns/rows 0, 3, 6 and
    // the right/bottom edge of the last cell closes the board.
    thick = ((px == 4'd0)  && (col_r inside {4'd0, 4'd3, 4'd6})) ||
            ((py == 4'd0)  && (row_r inside {4'd0, 4'd3, 4'd6})) ||
            ((px == 4'd15) && (col_r == 4'd8)) ||
            ((py == 4'd15) && (row_r == 4'd8));
    thin  = (px == 4'd0) || (py == 4'd0);
    ink_area = (px >= 4'd4) && (px <= 4'd11) &&
               (py >= 4'd4) && (py <= 4'd11) &&
               (dat_r >= 4'd1) && (dat_r <= 4'd9);
    ink = ink_area && glyph_bits[3'd7 - glyph_col];
    if (thick)     colour = PIX_THICK;
    else if (thin) colour = PIX_THIN;
    else if (ink)  colour = PIX_INK;
    else           colour = PIX_BG;
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    fb_we     = 1'b0;
    fb_x      = 8'd0;
    fb_y      = 8'd0;
    fb_pixel  = PIX_BG;
    busy      = 1'b0;
    cell_done = 1'b0;
    cell_err  = 1'b0;
    case (state)
      S_DRAW: begin
        fb_we    = 1'b1;
        fb_x     = 8'(GRID_X0) + 8'(col_r * CELL_PX) + 8'(px);
        fb_y     = 8'(GRID_Y0) + 8'(row_r * CELL_PX) + 8'(py);
        fb_pixel = colour;
        busy     = 1'b1;
      end
      S_DONE: begin
        busy      = 1'b1;
        cell_done = 1'b1;
        cell_err  = err_r;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
